instr_sequencer: RTL and testbench

//   Drives the mipscpu instruction interface (instrword, newinstr). A host loads a short

---
 rtl/instr_sequencer_pkg.sv | 30 +++
 rtl/instr_buffer.sv | 26 ++
 rtl/instr_sequencer.sv | 157 +++++++++++++++
 tb/tb_instr_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and helpers for the instruction sequencer: FSM state encoding,
// default halt sentinel and the inter-strobe gap reload computation.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam int          GAP_MIN           = 2;
    localparam int          GAP_MAX           = 255;

    // WAIT lasts gap-1 cycles; the down-counter expires on zero, so reload with gap-2.
    function automatic logic [7:0] wait_reload(input int gap);
        int g;
        g = gap;
        if (g < GAP_MIN) begin
            g = GAP_MIN;
        end else if (g > GAP_MAX) begin
            g = GAP_MAX;
        end else begin
            g = gap;
        end
        return 8'(g - 2);
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// Program store: DEPTH x 32 RAM, synchronous write from the loader,
// asynchronous read addressed by the sequencer's pc.
module instr_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset; the sequencer's count gates reachability.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Loads a short program from a host, then issues one word per slot to the CPU as
// a one-cycle newinstr strobe, GAP cycles apart, stopping at the end or a halt word.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          GAP       = 4,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_en,
    input  logic [31:0]   load_data,
    output logic          load_full,
    input  logic          start,
    output logic [31:0]   instrword,
    output logic          newinstr,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [7:0]    issued_count
);

    localparam logic [7:0]  WAIT_LOAD = wait_reload(GAP);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [31:0]   instrword_q, instrword_d;
    logic          newinstr_q, newinstr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_full_q, load_full_d;
    logic [7:0]    issued_q, issued_d;
    logic          mem_we;
    logic [31:0]   rd_word;

    instr_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    // Next-state, pointer, counter and output computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wait_cnt_d  = wait_cnt_q;
        instrword_d = instrword_q;
        issued_d    = issued_q;
        newinstr_d  = 1'b0;
        mem_we      = 1'b0;
        busy_d      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        done_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                // A same-cycle load takes priority over start.
                if (load_en && !load_full_q) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                end else if (start && (count_q != '0)) begin
                    state_d  = ST_ISSUE;
                    pc_d     = '0;
                    issued_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rd_word != HALT_WORD) begin
                    instrword_d = rd_word;
                    newinstr_d  = 1'b1;
                    issued_d    = (issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;
                    wait_cnt_d  = WAIT_LOAD;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q != 8'd0) begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end else if ({1'b0, pc_q} == (count_q - CNT_ONE)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + PTR_ONE;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d  = ST_ISSUE;
                    pc_d     = '0;
                    issued_d = 8'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_full_d = (count_d == CNT_FULL);
    end

    // State and output registers; reset overrides everything, even mid-run.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wait_cnt_q  <= 8'd0;
            instrword_q <= 32'd0;
            newinstr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_full_q <= 1'b0;
            issued_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wait_cnt_q  <= wait_cnt_d;
            instrword_q <= instrword_d;
            newinstr_q  <= newinstr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_full_q <= load_full_d;
            issued_q    <= issued_d;
        end
    end

    assign load_full    = load_full_q;
    assign instrword    = instrword_q;
    assign newinstr     = newinstr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pc           = pc_q;
    assign issued_count = issued_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected strobes
// (word and cycle) into a queue; a negedge monitor pops and compares each strobe.
module tb_instr_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_data = 32'd0;
    logic        start = 1'b0;
    logic        load_full, newinstr, busy, done;
    logic [31:0] instrword;
    logic [3:0]  pc;
    logic [7:0]  issued_count;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    instr_sequencer #(.DEPTH(16), .AW(4), .GAP(4), .HALT_WORD(HALT)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_en      (load_en),
        .load_data    (load_data),
        .load_full    (load_full),
        .start        (start),
        .instrword    (instrword),
        .newinstr     (newinstr),
        .busy         (busy),
        .done         (done),
        .pc           (pc),
        .issued_count (issued_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && newinstr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got word %h at cycle %0d, expected none", instrword, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_word", instrword, e.word);
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // All tasks are entered and left just after a negedge.
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic load(input logic [31:0] w);
        load_en = 1'b1;
        load_data = w;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w, input int c);
        exp_t e;
        e.word = w;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clock);
            k++;
        end
        dcyc = cyc;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic wait_strobe(input string name, input int budget);
        int k;
        k = 0;
        while (!newinstr && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (!newinstr) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no strobe after %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_instrword"}, instrword, 32'd0);
        chk({tag, "_newinstr"}, 32'(newinstr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_issued"}, 32'(issued_count), 32'd0);
        chk({tag, "_full"}, 32'(load_full), 32'd0);
    endtask

    logic [31:0] prog1 [3];

    initial begin
        int t;
        int d;
        prog1[0] = 32'h0022_1820;
        prog1[1] = 32'h8C41_0004;
        prog1[2] = 32'hAC41_0008;

        @(negedge clock);
        do_reset();
        check_idle_outputs("reset");

        // Test 1: three-word program, strobes every 4 cycles, done 4 after the last.
        for (int i = 0; i < 3; i++) load(prog1[i]);
        pulse_start(t);
        for (int i = 0; i < 3; i++) expect_word(prog1[i], t + 1 + 4 * i);
        wait_done("t1", 40, d);
        chk("t1_done_cycle", 32'(d), 32'(t + 13));
        chk("t1_issued", 32'(issued_count), 32'd3);
        chk("t1_pc", 32'(pc), 32'd2);
        chk("t1_last_word", instrword, prog1[2]);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: restart from DONE re-issues the retained program.
        pulse_start(t);
        for (int i = 0; i < 3; i++) expect_word(prog1[i], t + 1 + 4 * i);
        wait_strobe("t5", 10);
        chk("t5_issued_first", 32'(issued_count), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        wait_done("t5", 40, d);
        chk("t5_issued", 32'(issued_count), 32'd3);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 4: reset two cycles after the second strobe of a rerun.
        pulse_start(t);
        expect_word(prog1[0], t + 1);
        expect_word(prog1[1], t + 5);
        while (cyc < t + 7) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_idle_outputs("t4_reset");
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        pulse_start(t);
        repeat (8) @(negedge clock);
        chk("t4_no_run_busy", 32'(busy), 32'd0);
        chk("t4_no_run_issued", 32'(issued_count), 32'd0);

        // Test 2: halt word ends the program after one strobe.
        do_reset();
        load(32'h0022_1820);
        load(HALT);
        load(32'h0000_0000);
        pulse_start(t);
        expect_word(32'h0022_1820, t + 1);
        wait_done("t2", 30, d);
        chk("t2_pc", 32'(pc), 32'd1);
        chk("t2_issued", 32'(issued_count), 32'd1);
        chk("t2_word_held", instrword, 32'h0022_1820);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 3: seventeen loads into a 16-entry buffer.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            load(32'h1000_0000 + 32'(i));
            if (i == 15) chk("t3_not_full_15", 32'(load_full), 32'd0);
            if (i == 16) chk("t3_full_16", 32'(load_full), 32'd1);
        end
        chk("t3_full_17", 32'(load_full), 32'd1);
        pulse_start(t);
        for (int i = 0; i < 16; i++) expect_word(32'h1000_0001 + 32'(i), t + 1 + 4 * i);
        wait_done("t3", 100, d);
        chk("t3_done_cycle", 32'(d), 32'(t + 1 + 4 * 15 + 4));
        chk("t3_issued", 32'(issued_count), 32'd16);
        chk("t3_pc", 32'(pc), 32'd15);
        chk("t3_last_word", instrword, 32'h1000_0010);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 6: start on an empty buffer, then load_en and start together.
        do_reset();
        pulse_start(t);
        repeat (6) @(negedge clock);
        chk("t6_empty_busy", 32'(busy), 32'd0);
        chk("t6_empty_done", 32'(done), 32'd0);
        load_en = 1'b1;
        start = 1'b1;
        load_data = 32'h0123_4567;
        @(negedge clock);
        load_en = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("t6_same_cycle_busy", 32'(busy), 32'd0);
        chk("t6_same_cycle_issued", 32'(issued_count), 32'd0);
        pulse_start(t);
        expect_word(32'h0123_4567, t + 1);
        wait_done("t6", 20, d);
        chk("t6_one_word_issued", 32'(issued_count), 32'd1);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
